// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: 2-FF synchronizer, then a debounce FSM that produces a clean level and press/release strobes.
// Define HOLD_REPEAT_EN to add auto-repeat press pulses while the button is held.
module button_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned MAX_AB_C  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CNT_C = (MAX_AB_C > REPEAT_PERIOD) ? MAX_AB_C : REPEAT_PERIOD;
  localparam int unsigned CNT_W     = $clog2(MAX_CNT_C) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST_C = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  logic             sync1_r, sync2_r;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             level_r, level_s;
  logic             press_r, press_s;
  logic             release_r, release_s;
  logic             hold_fire_s;

  // Two-stage synchronizer; the FSM only ever looks at sync2_r.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce next-state logic: a pending state commits only after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    level_s   = level_r;
    press_s   = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (sync2_r) begin
          state_s = PRESS_PEND;
        end else begin
          state_s = IDLE;
        end
      end
      PRESS_PEND: begin
        if (!sync2_r) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else if (cnt_r == DEB_LAST_C) begin
          state_s = PRESSED;
          cnt_s   = '0;
          level_s = 1'b1;
          press_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      PRESSED: begin
        cnt_s = '0;
        if (!sync2_r) begin
          state_s = RELEASE_PEND;
        end else begin
          state_s = PRESSED;
        end
      end
      RELEASE_PEND: begin
        // A bounce back to 1 returns to PRESSED silently.
        if (sync2_r) begin
          state_s = PRESSED;
          cnt_s   = '0;
        end else if (cnt_r == DEB_LAST_C) begin
          state_s   = IDLE;
          cnt_s     = '0;
          level_s   = 1'b0;
          release_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        level_s = 1'b0;
      end
    endcase
  end

`ifdef HOLD_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST_C  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST_C = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s, hold_tgt_s;
  logic             rep_phase_r, rep_phase_s;

  // Auto-repeat timer: first gap is REPEAT_DELAY, later gaps (and after a bounce) are REPEAT_PERIOD.
  always_comb begin
    hold_cnt_s  = hold_cnt_r;
    rep_phase_s = rep_phase_r;
    hold_fire_s = 1'b0;
    hold_tgt_s  = rep_phase_r ? PERIOD_LAST_C : DELAY_LAST_C;
    if ((state_r == PRESSED) && sync2_r) begin
      if (hold_cnt_r == hold_tgt_s) begin
        hold_fire_s = 1'b1;
        hold_cnt_s  = '0;
        rep_phase_s = 1'b1;
      end else begin
        hold_cnt_s = hold_cnt_r + CNT_W'(1'b1);
      end
    end else begin
      hold_cnt_s  = '0;
      rep_phase_s = (state_r == PRESSED) || (state_r == RELEASE_PEND);
    end
  end

  // Auto-repeat timer registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_cnt_r  <= '0;
      rep_phase_r <= 1'b0;
    end else begin
      hold_cnt_r  <= hold_cnt_s;
      rep_phase_r <= rep_phase_s;
    end
  end
`else
  assign hold_fire_s = 1'b0;
`endif

  // FSM state, stability counter and registered outputs.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      level_r   <= level_s;
      press_r   <= press_s | hold_fire_s;
      release_r <= release_s;
    end
  end

  assign btn_level     = level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;

endmodule

// File: doc/button_debounce_pulse.md
Name: button_debounce_pulse

Overview:
- Conditions one raw push-button input (Basys3 pushbutton) before it reaches the downstream D-flip-flop edge/pulse stages and the UI FSMs.
- Function: 2-FF synchronizer, then a debounce FSM with a stability counter.
- Outputs: a clean level, a 1-cycle press pulse and a 1-cycle release pulse, all in the CLOCK domain.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized cycles required to accept a change (10 ms at 100 MHz); must be >= 1.
- REPEAT_DELAY, 50_000_000: held cycles before the first auto-repeat pulse (used only with HOLD_REPEAT_EN).
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeat pulses (used only with HOLD_REPEAT_EN); must be >= 1.

Ports:
- CLOCK  input  1  system clock, all logic on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- btn_raw  input  1  unsynchronized, bouncing button level (1 = pressed).
- btn_level  output  1  debounced level.
- press_pulse  output  1  one-cycle strobe on accepted press (and on auto-repeat if enabled).
- release_pulse  output  1  one-cycle strobe on accepted release.

Behaviour:
- Reset (RESET_N = 0, asynchronous):
  - sync1, sync2, counter, btn_level, press_pulse and release_pulse all go to 0; state = IDLE.
  - Reset takes effect immediately, including mid-debounce or mid-hold.
- Synchronizer: sync1 <= btn_raw; sync2 <= sync1. FSM sees only sync2.
- Counter width: $clog2 of the largest count parameter, +1. No wrap is possible; the counter always clears before the compare value.
- FSM states, all outputs registered:
  - IDLE (level 0): sync2 = 1 -> PRESS_PEND, cnt = 0.
  - PRESS_PEND (level 0): sync2 = 0 -> IDLE. Else if cnt == DEBOUNCE_CYCLES-1 -> PRESSED, btn_level <= 1, press_pulse <= 1. Else cnt++.
  - PRESSED (level 1): sync2 = 0 -> RELEASE_PEND, cnt = 0.
  - RELEASE_PEND (level 1): sync2 = 1 -> PRESSED, no pulse. Else if cnt == DEBOUNCE_CYCLES-1 -> IDLE, btn_level <= 0, release_pulse <= 1. Else cnt++.
- Pulses:
  - press_pulse and release_pulse are high for exactly one cycle, in the same cycle btn_level changes.
  - The two pulses are never high together.
- Latency:
  - Count edge 1 as the rising edge that first samples btn_raw = 1, with btn_raw held stable from then on.
  - btn_level rises on edge DEBOUNCE_CYCLES+3.
  - Release latency is the same.
- Bounce: any sync2 glitch shorter than DEBOUNCE_CYCLES restarts acceptance from scratch. No output change and no pulse.
- Button held through reset release: a full debounce runs from IDLE, then one press_pulse fires. A held button is reported as a new press.
- Equal stability while already in the matching stable state (IDLE with sync2 = 0, PRESSED with sync2 = 1): no action, counter idle.

Optional Feature:
- Macro: HOLD_REPEAT_EN.
- Defined:
  - In PRESSED with sync2 = 1, a hold counter runs.
  - It issues an extra 1-cycle press_pulse REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles while held.
  - The hold counter clears on leaving PRESSED and on reset.
  - On returning from RELEASE_PEND to PRESSED, it resumes from 0 toward REPEAT_PERIOD.
  - btn_level is unaffected.
- Undefined: no hold counter is synthesized. press_pulse fires exactly once per accepted press.

Test Plan (DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3 unless noted):
- Reset: RESET_N = 0 with btn_raw = 1 -> all outputs 0 asynchronously, before any CLOCK edge. After release with btn_raw still 1 -> btn_level = 1 and press_pulse high for 1 cycle on the 7th edge.
- Clean press: btn_raw 0->1 and held -> btn_level rises on edge 7. press_pulse is high only in that cycle. release_pulse stays 0.
- Bounce reject: btn_raw toggles 1,0,1,0 every 2 cycles, then stays 0 -> btn_level stays 0, no pulses. Repeat in the PRESSED state with short 0-glitches -> btn_level stays 1, no release_pulse.
- Clean release: from PRESSED, btn_raw 1->0 held -> btn_level falls on edge 7. release_pulse high for 1 cycle.
- Async reset mid-debounce: assert RESET_N in PRESS_PEND at cnt = 2 -> outputs stay 0. After release, the full 7-edge latency applies again.
- HOLD_REPEAT_EN, button held 30 cycles after acceptance -> press_pulses at acceptance +10, +13, +16 ... +28 (7 repeat pulses). Without the macro -> exactly 1 press_pulse.
